// File: rtl/vga_pkg.sv
// Shared timing constants for the luna VGA/LED top: 640x480@60 Hz at a 25 MHz pixel rate
// derived from the 100 MHz board clock.
package vga_pkg;

    typedef logic [9:0]  coord_t;
    typedef logic [15:0] frame_t;
    typedef logic [3:0]  nibble_t;

    localparam int CLK_DIV   = 4;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;

    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Counter-width versions so comparisons stay the same width as the counters.
    localparam coord_t H_VIS_C     = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS_C     = coord_t'(V_VISIBLE);
    localparam coord_t H_LAST      = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST      = coord_t'(V_TOTAL - 1);
    localparam coord_t H_SYNC_START = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t H_SYNC_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam coord_t V_SYNC_START = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t V_SYNC_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);

    localparam logic [1:0] PRE_LAST = 2'(CLK_DIV - 1);

    // Inclusive range test used for both sync windows.
    function automatic logic in_window(input coord_t value, input coord_t lo, input coord_t hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters advancing on the pixel tick, with combinational
// visible-area and sync terms for the current position.
module vga_timing
    import vga_pkg::*;
(
    input  logic   raw_clk,
    input  logic   rst,
    input  logic   tick,
    output coord_t hcount,
    output coord_t vcount,
    output logic   visible,
    output logic   hsync_term,
    output logic   vsync_term,
    output logic   frame_end
);

    coord_t hcount_r;
    coord_t vcount_r;

    // Raster position: h wraps at end of line and carries into v, v wraps at end of frame.
    always_ff @(posedge raw_clk) begin
        if (!rst) begin
            hcount_r <= 10'd0;
            vcount_r <= 10'd0;
        end else if (tick) begin
            if (hcount_r == H_LAST) begin
                hcount_r <= 10'd0;
                if (vcount_r == V_LAST) begin
                    vcount_r <= 10'd0;
                end else begin
                    vcount_r <= vcount_r + 10'd1;
                end
            end else begin
                hcount_r <= hcount_r + 10'd1;
            end
        end
    end

    // Position-derived terms; syncs are active low.
    always_comb begin
        visible    = 1'b0;
        hsync_term = 1'b1;
        vsync_term = 1'b1;
        frame_end  = 1'b0;
        if ((hcount_r < H_VIS_C) && (vcount_r < V_VIS_C)) begin
            visible = 1'b1;
        end else begin
            visible = 1'b0;
        end
        hsync_term = !in_window(hcount_r, H_SYNC_START, H_SYNC_END);
        vsync_term = !in_window(vcount_r, V_SYNC_START, V_SYNC_END);
        if (tick && (hcount_r == H_LAST) && (vcount_r == V_LAST)) begin
            frame_end = 1'b1;
        end else begin
            frame_end = 1'b0;
        end
    end

    assign hcount = hcount_r;
    assign vcount = vcount_r;

endmodule

// File: rtl/vga_led_top.sv
// luna board top: pixel-rate prescaler, frame counter and registered VGA/LED pin drivers.
// Every pin updates only on the pixel tick from the pre-increment raster position.
module vga_led_top
    import vga_pkg::*;
(
    input  logic        raw_clk,
    input  logic        rst,
    output logic [15:0] leds,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue
);

    logic [1:0] prescaler_r;
    frame_t     frame_r;
    logic       tick_s;
    coord_t     hcount_s;
    coord_t     vcount_s;
    logic       visible_s;
    logic       hsync_term_s;
    logic       vsync_term_s;
    logic       frame_end_s;
    nibble_t    red_s;
    nibble_t    green_s;
    nibble_t    blue_s;

    assign tick_s = (prescaler_r == PRE_LAST);

    // Divide-by-CLK_DIV clock enable; tick marks the last raw cycle of each pixel.
    always_ff @(posedge raw_clk) begin
        if (!rst) begin
            prescaler_r <= 2'd0;
        end else if (tick_s) begin
            prescaler_r <= 2'd0;
        end else begin
            prescaler_r <= prescaler_r + 2'd1;
        end
    end

    vga_timing u_timing (
        .raw_clk    (raw_clk),
        .rst        (rst),
        .tick       (tick_s),
        .hcount     (hcount_s),
        .vcount     (vcount_s),
        .visible    (visible_s),
        .hsync_term (hsync_term_s),
        .vsync_term (vsync_term_s),
        .frame_end  (frame_end_s)
    );

    // Frame counter, free-running with natural 16-bit wrap.
    always_ff @(posedge raw_clk) begin
        if (!rst) begin
            frame_r <= 16'd0;
        end else if (frame_end_s) begin
            frame_r <= frame_r + 16'd1;
        end
    end

    // Test pattern: coarse h/v gradients with the frame count on blue; black in blanking.
    always_comb begin
        red_s   = 4'd0;
        green_s = 4'd0;
        blue_s  = 4'd0;
        if (visible_s) begin
            red_s   = 4'(hcount_s >> 4);
            green_s = 4'(vcount_s >> 4);
            blue_s  = frame_r[3:0];
        end else begin
            red_s   = 4'd0;
            green_s = 4'd0;
            blue_s  = 4'd0;
        end
    end

    // Pin registers, one pixel tick behind the raster counters.
    always_ff @(posedge raw_clk) begin
        if (!rst) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            red   <= 4'd0;
            green <= 4'd0;
            blue  <= 4'd0;
            leds  <= 16'd0;
        end else if (tick_s) begin
            hsync <= hsync_term_s;
            vsync <= vsync_term_s;
            red   <= red_s;
            green <= green_s;
            blue  <= blue_s;
            leds  <= frame_r;
        end
    end

endmodule

// File: tb/tb_vga_led_top.sv
// Directed bench for vga_led_top: reset state, sync timing from release, pattern values,
// blanking, sync window edges, frame counting/wrap and mid-frame reset.
module tb_vga_led_top;

    logic        raw_clk = 1'b0;
    logic        rst     = 1'b0;
    logic [15:0] leds;
    logic        hsync;
    logic        vsync;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;
    int t_a;
    int t_b;
    int t_c;

    logic [9:0]  ph;
    logic [9:0]  pv;
    logic [15:0] pf;

    vga_led_top dut (
        .raw_clk (raw_clk),
        .rst     (rst),
        .leds    (leds),
        .hsync   (hsync),
        .vsync   (vsync),
        .red     (red),
        .green   (green),
        .blue    (blue)
    );

    always #5 raw_clk = ~raw_clk;

    // Edge index since reset release: the first edge sampling rst=1 is edge 1.
    always @(posedge raw_clk) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick_wait(input int n);
        repeat (4 * n) @(posedge raw_clk);
        #1;
    endtask

    // Wait for hsync (sel=0) or vsync (sel=1) to reach lvl; at=-1 if the budget runs out.
    task automatic wait_level(input int sel, input logic lvl, input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound; i++) begin
            @(posedge raw_clk);
            #1;
            if (((sel == 0) ? hsync : vsync) == lvl) begin
                at = cyc;
                break;
            end
        end
    endtask

    // Place the raster/frame state just after a tick edge; the next tick captures it.
    task preload(input logic [9:0] h, input logic [9:0] v, input logic [15:0] f);
        while ((cyc % 4) != 0) begin
            @(posedge raw_clk);
            #1;
        end
        ph = h;
        pv = v;
        pf = f;
        force dut.u_timing.hcount_r = ph;
        force dut.u_timing.vcount_r = pv;
        force dut.frame_r = pf;
        @(negedge raw_clk);
        release dut.u_timing.hcount_r;
        release dut.u_timing.vcount_r;
        release dut.frame_r;
    endtask

    initial begin
        rst = 1'b0;
        repeat (5) @(posedge raw_clk);
        #1;
        check("rst_hsync", 32'(hsync), 32'd1);
        check("rst_vsync", 32'(vsync), 32'd1);
        check("rst_red",   32'(red),   32'd0);
        check("rst_green", 32'(green), 32'd0);
        check("rst_blue",  32'(blue),  32'd0);
        check("rst_leds",  32'(leds),  32'd0);

        @(negedge raw_clk);
        rst = 1'b1;
        repeat (4) @(posedge raw_clk);
        #1;
        check("first_tick_hsync", 32'(hsync), 32'd1);
        check("first_tick_rgb",   32'({red, green, blue}), 32'd0);

        wait_level(0, 1'b0, 4000, t_a);
        check("hs_fall", 32'(t_a), 32'd2628);
        wait_level(0, 1'b1, 1000, t_b);
        check("hs_low_len", 32'(t_b - t_a), 32'd384);
        wait_level(0, 1'b0, 4000, t_c);
        check("hs_period", 32'(t_c - t_a), 32'd3200);

        preload(10'h05F, 10'h023, 16'd2);
        tick_wait(1);
        check("pix_red",   32'(red),   32'd5);
        check("pix_green", 32'(green), 32'd2);
        check("pix_blue",  32'(blue),  32'd2);
        check("pix_leds",  32'(leds),  32'd2);

        preload(10'd639, 10'd479, 16'd5);
        tick_wait(1);
        check("corner_red",   32'(red),   32'd7);
        check("corner_green", 32'(green), 32'd13);
        check("corner_blue",  32'(blue),  32'd5);

        preload(10'd640, 10'd100, 16'd3);
        tick_wait(1);
        check("blank_h", 32'({red, green, blue}), 32'd0);
        preload(10'd100, 10'd480, 16'd3);
        tick_wait(1);
        check("blank_v", 32'({red, green, blue}), 32'd0);

        preload(10'd655, 10'd10, 16'd0);
        tick_wait(1);
        check("hs_655", 32'(hsync), 32'd1);
        tick_wait(1);
        check("hs_656", 32'(hsync), 32'd0);
        preload(10'd751, 10'd10, 16'd0);
        tick_wait(1);
        check("hs_751", 32'(hsync), 32'd0);
        tick_wait(1);
        check("hs_752", 32'(hsync), 32'd1);

        preload(10'd799, 10'd489, 16'd0);
        tick_wait(1);
        check("vs_489", 32'(vsync), 32'd1);
        tick_wait(1);
        check("vs_490", 32'(vsync), 32'd0);
        t_a = cyc;
        wait_level(1, 1'b1, 7000, t_b);
        check("vs_low_len", 32'(t_b - t_a), 32'd6400);

        preload(10'd798, 10'd524, 16'd7);
        tick_wait(1);
        check("frm_before", 32'(leds), 32'd7);
        tick_wait(1);
        check("frm_last_px", 32'(leds), 32'd7);
        tick_wait(1);
        check("frm_step", 32'(leds), 32'd8);
        check("frm_blue", 32'(blue), 32'd8);

        preload(10'd799, 10'd524, 16'hFFFF);
        tick_wait(1);
        check("wrap_before", 32'(leds), 32'hFFFF);
        tick_wait(1);
        check("wrap_leds", 32'(leds), 32'd0);
        check("wrap_rgb",  32'({red, green, blue}), 32'd0);

        preload(10'd300, 10'd100, 16'd4);
        tick_wait(2);
        check("mid_leds", 32'(leds), 32'd4);
        @(negedge raw_clk);
        rst = 1'b0;
        @(posedge raw_clk);
        #1;
        check("mid_rst_leds",  32'(leds),  32'd0);
        check("mid_rst_hsync", 32'(hsync), 32'd1);
        check("mid_rst_rgb",   32'({red, green, blue}), 32'd0);
        @(negedge raw_clk);
        rst = 1'b1;
        wait_level(0, 1'b0, 4000, t_a);
        check("mid_hs_fall", 32'(t_a), 32'd2628);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_led_top.md
Name: vga_led_top

Overview:
- FPGA top level for the luna board: 640x480@60 Hz VGA timing with a deterministic test pattern, and a 16-LED status display.
- Runs from the single 100 MHz board clock. A divide-by-4 clock-enable produces the 25 MHz pixel rate; no derived clocks.
- Sits directly at the board pins: VGA connector with 4-bit RGB, and 16 LEDs.

Parameters:
- CLK_DIV, 4, raw_clk cycles per pixel tick.
- H_VISIBLE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixel ticks.
- V_VISIBLE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines.

Ports:
- raw_clk  in  1  100 MHz board clock; the only clock.
- rst  in  1  synchronous, active-low reset.
- leds  out  16  frame counter display.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- red  out  4  pixel red.
- green  out  4  pixel green.
- blue  out  4  pixel blue.

Behaviour:
- Reset: when rst=0 at a raw_clk rising edge, the following take effect next cycle and hold while rst=0:
  - prescaler=0, hcount=0, vcount=0, frame=0;
  - hsync=1, vsync=1;
  - red=green=blue=0, leds=0.
- Prescaler: 2-bit counter, 0..CLK_DIV-1, wraps. tick=1 when prescaler==CLK_DIV-1. The first tick is the 4th cycle after reset release.
- hcount (10 bit) advances only on tick, over 0..799. At 799 it wraps to 0 and vcount advances.
- vcount (10 bit) runs over 0..524. When h=799 and v=524 on a tick, both wrap to 0 and frame (16 bit) increments, wrapping at 0xFFFF to 0.
- Outputs are registered and updated only on tick, from the counter values before that tick's increment. Fixed latency is one pixel tick.
- hsync = 0 iff 656 <= hcount <= 751.
- vsync = 0 iff 490 <= vcount <= 491.
- Visible area is hcount<640 and vcount<480:
  - red = hcount[7:4];
  - green = vcount[7:4];
  - blue = frame[3:0].
- Outside the visible area, red/green/blue are 0.
- leds = frame, registered on the same tick.
- Timing totals: line = 800 ticks = 3200 raw_clk cycles; frame = 525 lines = 1,680,000 cycles.
- Reset mid-frame: all state returns to reset values on the next edge. Counting restarts from h=0, v=0 with no partial-sync glitch beyond that edge.
- No inputs other than reset; no handshakes.

Decomposition:
- Package vga_pkg holds the timing constants, the derived totals H_TOTAL=800 and V_TOTAL=525, and the sync start/end values.
- Sub-module vga_timing takes raw_clk, rst and tick, and produces hcount, vcount, visible, the hsync/vsync combinational terms, and a frame_end pulse.
- The top level holds the prescaler, the frame counter, and the registered outputs.

Test Plan:
- Reset: hold rst=0 for 5 cycles -> hsync=1, vsync=1, rgb=0, leds=0. Release -> first tick on cycle 4; red/green/blue remain 0 at h=0, v=0 for the first capture.
- Hsync: from reset release, hsync falls at cycle 2628 (tick 657), stays low exactly 384 cycles, then repeats every 3200 cycles.
- Vsync: vsync falls when vcount 490 is captured, stays low exactly 6400 cycles (2 lines), with a period of 1,680,000 cycles.
- Blanking: during hcount 640..799 or vcount 480..524, red=green=blue=0. At hcount=0x5F, vcount=0x23 with frame=2 -> red=5, green=2, blue=2.
- Frame counter: run 3 full frames -> leds steps 0,1,2,3, each change on the tick capturing h=0, v=0. Preload frame=0xFFFF via force -> next frame gives leds=0.
- Reset mid-operation: assert rst=0 at hcount=300, vcount=100 for 1 cycle -> counters return to 0 and the hsync-fall timing from release matches the first scenario.
